// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared FSM state type and power-of-two exponent helpers for
//                the streaming softmax normaliser.
//  Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

    // Normaliser control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2,
        DIV  = 2'd3
    } sm_state_e;

    // Widest exponent term and widest difference the helpers handle
    localparam int unsigned EXP_W_MAX = 64;
    localparam int unsigned D_W_MAX   = 16;

    // Unit value of the exponent term: 2^(exp_w-1)
    function automatic logic [EXP_W_MAX-1:0] exp_unit(input int unsigned exp_w);
        return {{(EXP_W_MAX-1){1'b0}}, 1'b1} << (exp_w - 1);
    endfunction

    // 2^(-d) scaled by the unit value; underflows to zero once d >= exp_w
    function automatic logic [EXP_W_MAX-1:0] exp2_shift(input logic [D_W_MAX-1:0] d,
                                                        input int unsigned      exp_w);
        if (32'(d) >= exp_w) begin
            return '0;
        end
        return exp_unit(exp_w) >> d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sm_div_seq
//  Description : Restoring unsigned divider, one quotient bit per cycle.
//                The caller guarantees dividend/divisor < 2^ALPHA_W, so the
//                upper SUM_W dividend bits seed the remainder directly and
//                only ALPHA_W iterations are needed. The first iteration is
//                performed on the start cycle; done_o pulses for one cycle
//                ALPHA_W cycles after start_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_div_seq #(
    parameter int SUM_W   = 38,
    parameter int ALPHA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [SUM_W+ALPHA_W-1:0]   dividend_i,
    input  logic [SUM_W-1:0]           divisor_i,
    output logic                       done_o,
    output logic [ALPHA_W-1:0]         quotient_o
);

    localparam int CNT_W = $clog2(ALPHA_W + 1);

    logic [SUM_W-1:0]   rem_q;
    logic [ALPHA_W-1:0] sh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic [SUM_W-1:0]   w_rem_in;
    logic [ALPHA_W-1:0] w_sh_in;
    logic [SUM_W:0]     w_trial;
    logic [SUM_W:0]     w_diff;
    logic               w_ge;

    // One restoring step, fed either by the new operands or by the running state
    always_comb begin
        w_rem_in = rem_q;
        w_sh_in  = sh_q;
        if (start_i) begin
            w_rem_in = dividend_i[SUM_W+ALPHA_W-1:ALPHA_W];
            w_sh_in  = dividend_i[ALPHA_W-1:0];
        end
        w_trial = {w_rem_in, w_sh_in[ALPHA_W-1]};
        w_ge    = (w_trial >= {1'b0, divisor_i});
        w_diff  = w_trial - {1'b0, divisor_i};
    end

    // Remainder/shift register: dividend bits leave at the top, quotient bits enter at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            sh_q  <= '0;
        end else if (start_i || (cnt_q != '0)) begin
            rem_q <= w_ge ? w_diff[SUM_W-1:0] : w_trial[SUM_W-1:0];
            sh_q  <= {w_sh_in[ALPHA_W-2:0], w_ge};
        end
    end

    // Iteration counter and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= CNT_W'(ALPHA_W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = sh_q;

endmodule
`default_nettype wire

// File: rtl/softmax_stream.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_stream
//  Description : Streaming softmax normaliser. Accepts a node count, buffers
//                that many signed coefficients while tracking their maximum,
//                sums 2^(c-max) terms, then divides each term by the sum and
//                emits alpha values (unsigned Q1.(ALPHA_W-1)) with a last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODES  = 168,
    parameter int EXP_W      = 32,
    parameter int ALPHA_W    = 32,
    parameter int NODE_W     = $clog2(MAX_NODES + 1),
    parameter int SUM_W      = EXP_W + NODE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cnt_vld_i,
    output logic                  cnt_rdy_o,
    input  logic [NODE_W-1:0]     cnt_i,
    input  logic                  coef_vld_i,
    output logic                  coef_rdy_o,
    input  logic [DATA_WIDTH-1:0] coef_i,
    output logic                  alpha_vld_o,
    input  logic                  alpha_rdy_i,
    output logic [ALPHA_W-1:0]    alpha_o,
    output logic                  alpha_last_o,
    output logic                  grp_done_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam int                IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [NODE_W-1:0] MAX_N = NODE_W'(MAX_NODES);
    localparam int                DVD_W = SUM_W + ALPHA_W;

    sm_state_e                    state_q;
    logic [NODE_W-1:0]            n_q;
    logic [IDX_W-1:0]             idx_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [SUM_W-1:0]             sum_q;
    logic                         cnt_rdy_q;
    logic                         coef_rdy_q;
    logic                         alpha_vld_q;
    logic [ALPHA_W-1:0]           alpha_q;
    logic                         alpha_last_q;
    logic                         grp_done_q;
    logic                         busy_q;
    logic                         ovf_q;
    logic                         start_q;

    logic [DATA_WIDTH-1:0]        buf_q [MAX_NODES];

    logic [NODE_W-1:0]            w_n_clamp;
    logic                         w_cnt_hs;
    logic                         w_coef_hs;
    logic                         w_alpha_hs;
    logic                         w_last_idx;
    logic [DATA_WIDTH-1:0]        w_rd;
    logic [DATA_WIDTH:0]          w_d;
    logic [EXP_W-1:0]             w_e;
    logic [DVD_W-1:0]             w_dividend;
    logic                         w_div_done;
    logic [ALPHA_W-1:0]           w_quot;
    logic                         w_coef_gt;

    // Handshakes, clamped count and the exponent term of the addressed entry
    always_comb begin
        w_cnt_hs   = cnt_vld_i && cnt_rdy_q;
        w_coef_hs  = coef_vld_i && coef_rdy_q;
        w_alpha_hs = alpha_vld_q && alpha_rdy_i;
        w_n_clamp  = (cnt_i > MAX_N) ? MAX_N : cnt_i;
        w_last_idx = (idx_q == IDX_W'(n_q - NODE_W'(1)));
        w_coef_gt  = ($signed(coef_i) > max_q);
        w_rd       = buf_q[idx_q];
        // max >= every buffered entry, so the widened difference is non-negative
        w_d        = {max_q[DATA_WIDTH-1], max_q} - {w_rd[DATA_WIDTH-1], w_rd};
        w_e        = EXP_W'(exp2_shift(D_W_MAX'(w_d), EXP_W));
        w_dividend = DVD_W'(w_e) << (ALPHA_W - 1);
    end

    // Coefficient buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if ((state_q == LOAD) && w_coef_hs) begin
            buf_q[idx_q] <= coef_i;
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            max_q        <= '0;
            sum_q        <= '0;
            cnt_rdy_q    <= 1'b0;
            coef_rdy_q   <= 1'b0;
            alpha_vld_q  <= 1'b0;
            alpha_q      <= '0;
            alpha_last_q <= 1'b0;
            grp_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            grp_done_q <= 1'b0;
            start_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_rdy_q  <= 1'b1;
                    coef_rdy_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (w_cnt_hs) begin
                        if (cnt_i > MAX_N) begin
                            ovf_q <= 1'b1;
                        end
                        n_q   <= w_n_clamp;
                        idx_q <= '0;
                        sum_q <= '0;
                        if (w_n_clamp == '0) begin
                            grp_done_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            cnt_rdy_q  <= 1'b0;
                            coef_rdy_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_coef_hs) begin
                        if ((idx_q == '0) || w_coef_gt) begin
                            max_q <= $signed(coef_i);
                        end
                        if (w_last_idx) begin
                            idx_q      <= '0;
                            coef_rdy_q <= 1'b0;
                            state_q    <= SUM;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                SUM: begin
                    sum_q <= sum_q + SUM_W'(w_e);
                    if (w_last_idx) begin
                        idx_q   <= '0;
                        start_q <= 1'b1;
                        state_q <= DIV;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        alpha_q      <= w_quot;
                        alpha_vld_q  <= 1'b1;
                        alpha_last_q <= w_last_idx;
                    end
                    if (w_alpha_hs) begin
                        alpha_vld_q  <= 1'b0;
                        alpha_last_q <= 1'b0;
                        if (alpha_last_q) begin
                            idx_q      <= '0;
                            grp_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            cnt_rdy_q  <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            start_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sm_div_seq #(
        .SUM_W   (SUM_W),
        .ALPHA_W (ALPHA_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_q),
        .dividend_i (w_dividend),
        .divisor_i  (sum_q),
        .done_o     (w_div_done),
        .quotient_o (w_quot)
    );

    assign cnt_rdy_o    = cnt_rdy_q;
    assign coef_rdy_o   = coef_rdy_q;
    assign alpha_vld_o  = alpha_vld_q;
    assign alpha_o      = alpha_q;
    assign alpha_last_o = alpha_last_q;
    assign grp_done_o   = grp_done_q;
    assign busy_o       = busy_q;
    assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_stream
//  Description : Directed self-checking bench for softmax_stream
//                (DATA_WIDTH=8, EXP_W=16, ALPHA_W=16, MAX_NODES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_stream;

    localparam int DW   = 8;
    localparam int MAXN = 8;
    localparam int EW   = 16;
    localparam int AW   = 16;
    localparam int NW   = 4;
    localparam int SW   = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_vld_i = 1'b0;
    logic          cnt_rdy_o;
    logic [NW-1:0] cnt_i = '0;
    logic          coef_vld_i = 1'b0;
    logic          coef_rdy_o;
    logic [DW-1:0] coef_i = '0;
    logic          alpha_vld_o;
    logic          alpha_rdy_i = 1'b0;
    logic [AW-1:0] alpha_o;
    logic          alpha_last_o;
    logic          grp_done_o;
    logic          busy_o;
    logic          ovf_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    softmax_stream #(
        .DATA_WIDTH (DW),
        .MAX_NODES  (MAXN),
        .EXP_W      (EW),
        .ALPHA_W    (AW),
        .NODE_W     (NW),
        .SUM_W      (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_vld_i    (cnt_vld_i),
        .cnt_rdy_o    (cnt_rdy_o),
        .cnt_i        (cnt_i),
        .coef_vld_i   (coef_vld_i),
        .coef_rdy_o   (coef_rdy_o),
        .coef_i       (coef_i),
        .alpha_vld_o  (alpha_vld_o),
        .alpha_rdy_i  (alpha_rdy_i),
        .alpha_o      (alpha_o),
        .alpha_last_o (alpha_last_o),
        .grp_done_o   (grp_done_o),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cnt(input logic [NW-1:0] n);
        bit ok = 1'b0;
        cnt_i     = n;
        cnt_vld_i = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (cnt_rdy_o) ok = 1'b1;
            cyc();
        end
        cnt_vld_i = 1'b0;
        chk("cnt_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_coef(input logic [DW-1:0] v, input int gap);
        bit ok = 1'b0;
        repeat (gap) cyc();
        coef_i     = v;
        coef_vld_i = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (coef_rdy_o) ok = 1'b1;
            cyc();
        end
        coef_vld_i = 1'b0;
        chk("coef_accept", 32'(ok), 32'd1);
    endtask

    task automatic recv(input string tag, input logic [AW-1:0] ev, input logic el, input int stall);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (alpha_vld_o) seen = 1'b1;
            else cyc();
        end
        chk({tag, "_vld"}, 32'(seen), 32'd1);
        repeat (stall) begin
            cyc();
            chk({tag, "_hold"}, 32'({alpha_vld_o, alpha_last_o, alpha_o}), 32'({1'b1, el, ev}));
        end
        chk({tag, "_val"}, 32'(alpha_o), 32'(ev));
        chk({tag, "_last"}, 32'(alpha_last_o), 32'(el));
        alpha_rdy_i = 1'b1;
        cyc();
        alpha_rdy_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_outputs", 32'({cnt_rdy_o, coef_rdy_o, alpha_vld_o, alpha_last_o,
                                grp_done_o, busy_o, ovf_o}), 32'd0);
        chk("rst_alpha", 32'(alpha_o), 32'd0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_cnt_rdy", 32'(cnt_rdy_o), 32'd1);
        chk("idle_coef_rdy", 32'(coef_rdy_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // N=1, coef 5
        send_cnt(4'd1);
        chk("n1_busy", 32'(busy_o), 32'd1);
        send_coef(8'd5, 0);
        recv("n1_a0", 16'h8000, 1'b1, 0);
        chk("n1_done", 32'(grp_done_o), 32'd1);
        cyc();
        chk("n1_done_pulse", 32'(grp_done_o), 32'd0);

        // N=2, coefs 3,3
        send_cnt(4'd2);
        send_coef(8'd3, 0);
        send_coef(8'd3, 0);
        recv("n2_a0", 16'h4000, 1'b0, 0);
        recv("n2_a1", 16'h4000, 1'b1, 0);
        chk("n2_done", 32'(grp_done_o), 32'd1);

        // N=4, coefs 2,1,0,-1 -> sum 61440
        send_cnt(4'd4);
        send_coef(8'd2, 0);
        send_coef(8'd1, 0);
        send_coef(8'd0, 0);
        send_coef(8'hFF, 0);
        recv("n4_a0", 16'h4444, 1'b0, 0);
        recv("n4_a1", 16'h2222, 1'b0, 0);
        recv("n4_a2", 16'h1111, 1'b0, 0);
        recv("n4_a3", 16'h0888, 1'b1, 0);
        chk("n4_done", 32'(grp_done_o), 32'd1);

        // Saturated difference: 127, -128
        send_cnt(4'd2);
        send_coef(8'd127, 0);
        send_coef(8'h80, 0);
        recv("sat_a0", 16'h8000, 1'b0, 0);
        recv("sat_a1", 16'h0000, 1'b1, 0);

        // Backpressure rerun of the N=4 group with a competing count held offered
        send_cnt(4'd4);
        cnt_i     = 4'd1;
        cnt_vld_i = 1'b1;
        send_coef(8'd2, 2);
        chk("bp_cnt_blocked", 32'(cnt_rdy_o), 32'd0);
        send_coef(8'd1, 0);
        send_coef(8'd0, 3);
        chk("bp_coef_busy", 32'(busy_o), 32'd1);
        send_coef(8'hFF, 1);
        chk("bp_no_coef_sum", 32'(coef_rdy_o), 32'd0);
        recv("bp_a0", 16'h4444, 1'b0, 3);
        chk("bp_cnt_blocked_div", 32'(cnt_rdy_o), 32'd0);
        recv("bp_a1", 16'h2222, 1'b0, 0);
        recv("bp_a2", 16'h1111, 1'b0, 2);
        recv("bp_a3", 16'h0888, 1'b1, 1);
        chk("bp_done", 32'(grp_done_o), 32'd1);
        chk("bp_idle_rdy", 32'(cnt_rdy_o), 32'd1);
        cyc();
        cnt_vld_i = 1'b0;
        chk("bp_cnt_taken", 32'({busy_o, coef_rdy_o}), 32'd3);
        send_coef(8'd7, 0);
        recv("bp_next_a0", 16'h8000, 1'b1, 0);

        // Zero count: completion pulse only
        send_cnt(4'd0);
        chk("n0_done", 32'(grp_done_o), 32'd1);
        chk("n0_state", 32'({busy_o, alpha_vld_o, coef_rdy_o}), 32'd0);
        cyc();
        chk("n0_pulse", 32'(grp_done_o), 32'd0);

        // Oversized count clamps to 8 and sets the sticky overflow flag
        chk("ovf_clear", 32'(ovf_o), 32'd0);
        send_cnt(4'd9);
        chk("ovf_set", 32'(ovf_o), 32'd1);
        for (int i = 0; i < 8; i++) send_coef(8'd0, 0);
        chk("ovf_eight_coefs", 32'(coef_rdy_o), 32'd0);
        for (int i = 0; i < 8; i++) recv("ovf_a", 16'h1000, (i == 7), 0);
        chk("ovf_done", 32'(grp_done_o), 32'd1);
        chk("ovf_sticky", 32'(ovf_o), 32'd1);

        // Reset in the middle of DIV
        send_cnt(4'd2);
        send_coef(8'd3, 0);
        send_coef(8'd3, 0);
        repeat (8) cyc();
        chk("mid_busy", 32'({busy_o, alpha_vld_o}), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({cnt_rdy_o, coef_rdy_o, alpha_vld_o, alpha_last_o,
                                    grp_done_o, busy_o, ovf_o}), 32'd0);
        chk("mid_rst_alpha", 32'(alpha_o), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        send_cnt(4'd2);
        send_coef(8'd127, 0);
        send_coef(8'h80, 0);
        recv("post_a0", 16'h8000, 1'b0, 0);
        recv("post_a1", 16'h0000, 1'b1, 0);
        chk("post_done", 32'(grp_done_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
